// File: rtl/mips32_mem_pkg.sv
// +----------------------------------------------------------------------+
// | mips32_mem_pkg : shared types/constants for the unified memory port   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package mips32_mem_pkg;
  localparam int AW_DEF   = 10;
  localparam int DW_DEF   = 32;
  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_D    = 2'd2
  } rsp_owner_t;
endpackage

`default_nettype wire

// File: rtl/mips32_starve_ctr.sv
// +----------------------------------------------------------------------+
// | mips32_starve_ctr : saturating fetch-starvation counter              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mips32_starve_ctr
  import mips32_mem_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk1,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [STARVE_W-1:0] MAX_C = STARVE_W'(MAX);

  logic [STARVE_W-1:0] r_count;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != MAX_C)) begin
      r_count <= r_count + STARVE_W'(1);
    end
  end

  assign at_max = (r_count == MAX_C);

endmodule

`default_nettype wire

// File: rtl/mips32_mem_arbiter.sv
// +----------------------------------------------------------------------+
// | mips32_mem_arbiter : IF/MEM arbiter for the unified single-port SRAM |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mips32_mem_arbiter
  import mips32_mem_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          fetch_starved
);

  rsp_owner_t r_owner;
  logic       w_at_max;

  mips32_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk1   (clk1),
    .rst_n  (rst_n),
    .inc    (if_req & d_gnt),
    .clr    (if_gnt | ~if_req),
    .at_max (w_at_max)
  );

  assign fetch_starved = w_at_max;

  // Grants are gated by rst_n so nothing reaches the SRAM while reset is held.
  assign if_gnt = rst_n & if_req & (w_at_max | ~d_req);
  assign d_gnt  = rst_n & d_req & ~if_gnt;

  assign mem_en    = if_gnt | d_gnt;
  assign mem_we    = d_gnt & d_we;
  assign mem_addr  = d_gnt ? d_addr : if_addr;
  assign mem_wdata = d_wdata;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= RSP_NONE;
    end else if (if_gnt && !if_flush) begin
      r_owner <= RSP_IF;
    end else if (d_gnt && !d_we) begin
      r_owner <= RSP_D;
    end else begin
      r_owner <= RSP_NONE;
    end
  end

  assign if_rvalid = (r_owner == RSP_IF) & ~if_flush;
  assign d_rvalid  = (r_owner == RSP_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mips32_mem_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mips32_mem_arbiter : directed + randomized checks with SRAM model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mips32_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0, if_flush = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, fetch_starved;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  int checks = 0;
  int failures = 0;

  mips32_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fetch_starved(fetch_starved)
  );

  always #5 clk1 = ~clk1;

  // Synchronous SRAM environment: read data appears one cycle after the access.
  always @(posedge clk1) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic tick;
    @(posedge clk1);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    repeat (2) @(posedge clk1);
    #4;
    checks += 6;
    if (if_gnt !== 1'b0)        begin failures++; $display("FAIL rst_if_gnt got=%b exp=0", if_gnt); end
    if (d_gnt !== 1'b0)         begin failures++; $display("FAIL rst_d_gnt got=%b exp=0", d_gnt); end
    if (mem_en !== 1'b0)        begin failures++; $display("FAIL rst_mem_en got=%b exp=0", mem_en); end
    if (if_rvalid !== 1'b0)     begin failures++; $display("FAIL rst_if_rvalid got=%b exp=0", if_rvalid); end
    if (d_rvalid !== 1'b0)      begin failures++; $display("FAIL rst_d_rvalid got=%b exp=0", d_rvalid); end
    if (fetch_starved !== 1'b0) begin failures++; $display("FAIL rst_starved got=%b exp=0", fetch_starved); end
    if_req = 1'b0; d_req = 1'b0;
    tick;
    rst_n = 1'b1;
    #4;
    checks += 2;
    if (d_rvalid !== 1'b0)      begin failures++; $display("FAIL rel_d_rvalid got=%b exp=0", d_rvalid); end
    if (mem_en !== 1'b0)        begin failures++; $display("FAIL rel_mem_en got=%b exp=0", mem_en); end
  endtask

  task automatic test_fetch_only;
    for (int i = 0; i < 4; i++) begin
      tick;
      if_req  = (i < 3);
      if_addr = AW'(i);
      #4;
      checks += 2;
      if (if_gnt !== (i < 3))   begin failures++; $display("FAIL fo_if_gnt[%0d] got=%b exp=%b", i, if_gnt, (i < 3)); end
      if (if_rvalid !== (i > 0)) begin failures++; $display("FAIL fo_if_rvalid[%0d] got=%b exp=%b", i, if_rvalid, (i > 0)); end
      if (i > 0) begin
        checks++;
        if (if_rdata !== 32'(32'h100 + i - 1)) begin
          failures++; $display("FAIL fo_if_rdata[%0d] got=%h exp=%h", i, if_rdata, 32'(32'h100 + i - 1));
        end
      end
    end
    if_req = 1'b0;
  endtask

  task automatic test_contention;
    logic exp_if;
    tick;
    if_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < 3 * (SM + 1); k++) begin
      tick;
      if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 10'd1; d_addr = 10'd2;
      #4;
      exp_if = ((k % (SM + 1)) == SM);
      checks += 3;
      if (if_gnt !== exp_if)        begin failures++; $display("FAIL ct_if_gnt[%0d] got=%b exp=%b", k, if_gnt, exp_if); end
      if (d_gnt !== !exp_if)        begin failures++; $display("FAIL ct_d_gnt[%0d] got=%b exp=%b", k, d_gnt, !exp_if); end
      if (fetch_starved !== exp_if) begin failures++; $display("FAIL ct_starved[%0d] got=%b exp=%b", k, fetch_starved, exp_if); end
    end
    tick;
    if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_store_load;
    tick;
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'd7; d_wdata = 32'hDEADBEEF;
    #4;
    checks += 2;
    if (d_gnt !== 1'b1)  begin failures++; $display("FAIL sl_st_gnt got=%b exp=1", d_gnt); end
    if (mem_we !== 1'b1) begin failures++; $display("FAIL sl_mem_we got=%b exp=1", mem_we); end
    ref_mem[7] = 32'hDEADBEEF;
    tick;
    d_we = 1'b0;
    #4;
    checks += 2;
    if (d_rvalid !== 1'b0) begin failures++; $display("FAIL sl_st_rvalid got=%b exp=0", d_rvalid); end
    if (mem_we !== 1'b0)   begin failures++; $display("FAIL sl_ld_mem_we got=%b exp=0", mem_we); end
    tick;
    d_we = 1'b1; d_addr = 10'd8; d_wdata = 32'hCAFEF00D;
    #4;
    checks += 2;
    if (d_rvalid !== 1'b1)        begin failures++; $display("FAIL sl_ld_rvalid got=%b exp=1", d_rvalid); end
    if (d_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sl_ld_rdata got=%h exp=deadbeef", d_rdata); end
    ref_mem[8] = 32'hCAFEF00D;
    tick;
    d_req = 1'b0; d_we = 1'b0;
    #4;
    checks++;
    if (d_rvalid !== 1'b0) begin failures++; $display("FAIL sl_st2_rvalid got=%b exp=0", d_rvalid); end
    tick;
    d_req = 1'b1; d_addr = 10'd8;
    tick;
    d_req = 1'b0;
    #4;
    checks += 2;
    if (d_rvalid !== 1'b1)        begin failures++; $display("FAIL sl_ld2_rvalid got=%b exp=1", d_rvalid); end
    if (d_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL sl_ld2_rdata got=%h exp=cafef00d", d_rdata); end
  endtask

  task automatic test_flush;
    tick;
    if_req = 1'b1; if_addr = 10'd5;
    #4;
    checks++;
    if (if_gnt !== 1'b1) begin failures++; $display("FAIL fl_gnt0 got=%b exp=1", if_gnt); end
    tick;
    if_addr = 10'd6; if_flush = 1'b1;
    #4;
    checks += 2;
    if (if_rvalid !== 1'b0) begin failures++; $display("FAIL fl_rvalid1 got=%b exp=0", if_rvalid); end
    if (if_gnt !== 1'b1)    begin failures++; $display("FAIL fl_gnt1 got=%b exp=1", if_gnt); end
    tick;
    if_req = 1'b0; if_flush = 1'b0;
    #4;
    checks++;
    if (if_rvalid !== 1'b0) begin failures++; $display("FAIL fl_rvalid2 got=%b exp=0", if_rvalid); end
    tick;
    if_flush = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 10'd3;
    tick;
    if_flush = 1'b0; d_req = 1'b0;
    #4;
    checks += 2;
    if (d_rvalid !== 1'b1)      begin failures++; $display("FAIL fl_d_rvalid got=%b exp=1", d_rvalid); end
    if (d_rdata !== ref_mem[3]) begin failures++; $display("FAIL fl_d_rdata got=%h exp=%h", d_rdata, ref_mem[3]); end
  endtask

  task automatic test_reset_mid;
    tick;
    for (int k = 0; k < SM; k++) begin
      tick;
      if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 10'd4;
      #4;
      checks++;
      if (d_gnt !== 1'b1) begin failures++; $display("FAIL rm_d_gnt[%0d] got=%b exp=1", k, d_gnt); end
    end
    tick;
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0;
    #4;
    checks += 2;
    if (d_rvalid !== 1'b0)      begin failures++; $display("FAIL rm_d_rvalid got=%b exp=0", d_rvalid); end
    if (fetch_starved !== 1'b0) begin failures++; $display("FAIL rm_starved got=%b exp=0", fetch_starved); end
    tick;
    tick;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #4;
      checks += 2;
      if (d_rvalid !== 1'b0)      begin failures++; $display("FAIL rm_rel_rvalid[%0d] got=%b exp=0", k, d_rvalid); end
      if (fetch_starved !== 1'b0) begin failures++; $display("FAIL rm_rel_starved[%0d] got=%b exp=0", k, fetch_starved); end
      tick;
    end
  endtask

  task automatic test_random;
    int            lose_cnt = 0;
    logic          if_hold = 1'b0, d_hold = 1'b0;
    logic          pend_if = 1'b0, pend_d = 1'b0;
    logic [DW-1:0] pend_if_data = '0, pend_d_data = '0;
    logic          exp_starved, exp_if, exp_d;
    for (int n = 0; n < 400; n++) begin
      tick;
      if (!if_hold) begin
        if_req  = 1'($urandom_range(0, 1));
        if_addr = AW'($urandom_range(0, 15));
      end
      if (!d_hold) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = AW'($urandom_range(0, 15));
        d_wdata = $urandom;
      end
      if_flush = ($urandom_range(0, 5) == 0);
      #4;
      // Expected behaviour from the arbitration rules: data wins unless fetch lost SM cycles in a row.
      exp_starved = (lose_cnt == SM);
      exp_if = if_req && (exp_starved || !d_req);
      exp_d  = d_req && !exp_if;
      checks += 5;
      if (if_gnt !== exp_if)                 begin failures++; $display("FAIL rnd_if_gnt[%0d] got=%b exp=%b", n, if_gnt, exp_if); end
      if (d_gnt !== exp_d)                   begin failures++; $display("FAIL rnd_d_gnt[%0d] got=%b exp=%b", n, d_gnt, exp_d); end
      if (fetch_starved !== exp_starved)     begin failures++; $display("FAIL rnd_starved[%0d] got=%b exp=%b", n, fetch_starved, exp_starved); end
      if (if_rvalid !== (pend_if && !if_flush)) begin failures++; $display("FAIL rnd_if_rvalid[%0d] got=%b exp=%b", n, if_rvalid, pend_if && !if_flush); end
      if (d_rvalid !== pend_d)               begin failures++; $display("FAIL rnd_d_rvalid[%0d] got=%b exp=%b", n, d_rvalid, pend_d); end
      if (exp_if || exp_d) begin
        checks += 2;
        if (mem_addr !== (exp_d ? d_addr : if_addr)) begin failures++; $display("FAIL rnd_mem_addr[%0d] got=%h exp=%h", n, mem_addr, exp_d ? d_addr : if_addr); end
        if (mem_we !== (exp_d && d_we))              begin failures++; $display("FAIL rnd_mem_we[%0d] got=%b exp=%b", n, mem_we, exp_d && d_we); end
      end else begin
        checks++;
        if (mem_en !== 1'b0) begin failures++; $display("FAIL rnd_mem_en[%0d] got=%b exp=0", n, mem_en); end
      end
      if (pend_if && !if_flush) begin
        checks++;
        if (if_rdata !== pend_if_data) begin failures++; $display("FAIL rnd_if_rdata[%0d] got=%h exp=%h", n, if_rdata, pend_if_data); end
      end
      if (pend_d) begin
        checks++;
        if (d_rdata !== pend_d_data) begin failures++; $display("FAIL rnd_d_rdata[%0d] got=%h exp=%h", n, d_rdata, pend_d_data); end
      end
      pend_if      = exp_if && !if_flush;
      pend_if_data = ref_mem[if_addr];
      pend_d       = exp_d && !d_we;
      pend_d_data  = ref_mem[d_addr];
      if (exp_d && d_we) ref_mem[d_addr] = d_wdata;
      if (exp_if || !if_req) lose_cnt = 0;
      else if (exp_d && lose_cnt < SM) lose_cnt++;
      if_hold = if_req && !exp_if;
      d_hold  = d_req && !exp_d;
    end
    tick;
    if_req = 1'b0; d_req = 1'b0; if_flush = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = 32'(32'h100 + i);
      ref_mem[i] = 32'(32'h100 + i);
    end
    test_reset;
    test_fetch_only;
    test_contention;
    test_store_load;
    test_flush;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
